// File: rtl/ysyx_pkg.sv
// ysyx_pkg: types and defaults shared between the fetch queue and the IDU.
//   YSYX_IFQ_DEPTH  default queue depth (overridable on the command line)
//   ifq_entry_t     one fetched beat {inst, pc, speculation}; the IDU input
//                   latch stores the same structure.
`ifndef YSYX_IFQ_DEPTH
`define YSYX_IFQ_DEPTH 4
`endif

package ysyx_pkg;

  localparam int unsigned YSYX_BIT_W = 32;
  localparam int unsigned IFQ_DEPTH  = `YSYX_IFQ_DEPTH;

  typedef struct packed {
    logic [31:0]            inst;
    logic [YSYX_BIT_W-1:0]  pc;
    logic                   speculation;
  } ifq_entry_t;

endpackage

// File: rtl/ysyx_ifq.sv
// ysyx_ifq: instruction fetch queue between the fetch unit and the IDU.
// Buffers {inst, pc, speculation} beats and presents them in program order
// on a valid/ready link. Flush drops every entry.
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   flush                  drop all entries; in-flight beat is discarded
//   in_valid/in_ready      push handshake from fetch
//   in_inst/in_pc/in_speculation  pushed beat
//   valid_o/next_ready     pop handshake toward the IDU
//   inst_o/pc_o/speculation_o     head beat, zero when !valid_o
//   count_o                occupancy
//
// Optional feature: define YSYX_IFQ_BYPASS_EN to let a beat arriving at an
// empty queue drive the outputs in the same cycle (zero-latency fetch->IDU).
// Without it there is no combinational path from in_* to the outputs.
module ysyx_ifq
  import ysyx_pkg::*;
#(
  parameter int unsigned BIT_W = YSYX_BIT_W,
  parameter int unsigned DEPTH = IFQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [31:0]            in_inst,
  input  logic [BIT_W-1:0]       in_pc,
  input  logic                   in_speculation,
  output logic                   in_ready,
  output logic                   valid_o,
  output logic [31:0]            inst_o,
  output logic [BIT_W-1:0]       pc_o,
  output logic                   speculation_o,
  input  logic                   next_ready,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  ifq_entry_t mem_q [DEPTH];

  ifq_entry_t in_entry;
  ifq_entry_t head;
  logic       empty;
  logic       full;
  logic       bypass;
  logic       push;
  logic       pop;

  assign in_entry.inst        = in_inst;
  assign in_entry.pc          = in_pc;
  assign in_entry.speculation = in_speculation;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // in_ready depends on registered occupancy only, so the IDU's ready never
  // reaches back into the fetch unit.
  assign in_ready = !full;

`ifdef YSYX_IFQ_BYPASS_EN
  // Gated by rst so outputs stay at reset values while reset is held.
  assign bypass = empty & in_valid & !flush & rst;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    head    = mem_q[rd_ptr_q];
    valid_o = !empty;
    if (bypass) begin
      head    = in_entry;
      valid_o = 1'b1;
    end
  end

  assign inst_o        = valid_o ? head.inst        : 32'h0;
  assign pc_o          = valid_o ? head.pc          : '0;
  assign speculation_o = valid_o ? head.speculation : 1'b0;
  assign count_o       = count_q;

  // A bypassed beat taken by the IDU in the same cycle is never written.
  always_comb begin
    pop  = !empty & next_ready & !flush;
    push = in_valid & in_ready & !flush & !(bypass & next_ready);
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

endmodule

// File: tb/tb_ysyx_ifq.sv
module tb_ysyx_ifq;
  import ysyx_pkg::*;

  localparam int DEPTH = 4;
`ifdef YSYX_IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        in_speculation = 1'b0;
  logic        in_ready;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        speculation_o;
  logic        next_ready = 1'b0;
  logic [2:0]  count_o;

  int total = 0;
  int bad   = 0;

  ifq_entry_t q[$];

  always #5 clk = ~clk;

  ysyx_ifq dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .in_speculation(in_speculation), .in_ready(in_ready),
    .valid_o(valid_o), .inst_o(inst_o), .pc_o(pc_o),
    .speculation_o(speculation_o), .next_ready(next_ready),
    .count_o(count_o)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Compare the DUT against the queue model with the current inputs, then
  // advance one clock and apply the model's view of that edge.
  task automatic cyc();
    logic        e_valid;
    ifq_entry_t  e_head;
    bit          took;
    #1;
    e_valid = (q.size() != 0) || (BYP && in_valid && !flush);
    e_head  = '0;
    if (q.size() != 0) e_head = q[0];
    else if (e_valid) e_head = '{inst: in_inst, pc: in_pc, speculation: in_speculation};
    chk("valid_o",  valid_o, e_valid);
    chk("inst_o",   inst_o, e_head.inst);
    chk("pc_o",     pc_o, e_head.pc);
    chk("spec_o",   speculation_o, e_head.speculation);
    chk("in_ready", in_ready, q.size() != DEPTH);
    chk("count_o",  count_o, q.size());
    @(posedge clk);
    if (flush) q.delete();
    else begin
      took = (q.size() == 0) && e_valid && next_ready;
      if (!took) begin
        bit do_push;
        do_push = in_valid && (q.size() != DEPTH);
        if (e_valid && next_ready) void'(q.pop_front());
        if (do_push) q.push_back('{inst: in_inst, pc: in_pc, speculation: in_speculation});
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic sp, input logic nr, input logic fl);
    in_valid = v; in_inst = inst; in_pc = pc; in_speculation = sp;
    next_ready = nr; flush = fl;
  endtask

  initial begin
    // reset values
    #2;
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_count", count_o, 0);
    chk("rst_inst",  inst_o, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // mid-stream async reset with three entries
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h13 + i, 32'h100 + 4*i, 0, 0, 0);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("pre_rst_count", count_o, 3);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", valid_o, 1'b0);
    chk("async_ready", in_ready, 1'b1);
    chk("async_count", count_o, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // fill, then hold a fifth beat against a full queue
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hA000_0000 + i, 32'h8000_0000 + 4*i, i[0], 0, 0);
      cyc();
    end
    chk("fill_count", count_o, 4);
    chk("fill_ready", in_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'hA000_0004, 32'h8000_0010, 0, 0, 0);
      cyc();
    end
    chk("held_count", count_o, 4);

    // drain in order
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain_pc", pc_o, 32'h8000_0000 + 4*i);
      cyc();
    end
    chk("drained_valid", valid_o, 1'b0);
    chk("drained_inst",  inst_o, 0);

    // the held fifth beat is still delivered afterwards
    drive(1, 32'hA000_0004, 32'h8000_0010, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("fifth_pc", pc_o, 32'h8000_0010);
    drive(0, 0, 0, 0, 1, 0);
    cyc();

    // stall hold
    drive(1, 32'h0050_0093, 32'h8000_0100, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_inst", inst_o, 32'h0050_0093);
      chk("hold_pc",   pc_o, 32'h8000_0100);
      cyc();
    end

    // flush race at count=2
    drive(1, 32'h1111, 32'h8000_0200, 1, 0, 0);
    cyc();
    chk("race_count2", count_o, 2);
    drive(1, 32'hDEAD, 32'h8000_0300, 0, 1, 1);
    cyc();
    chk("race_count", count_o, 0);
    chk("race_valid", valid_o, 1'b0);
    drive(0, 0, 0, 0, 1, 0);
    cyc();
    chk("race_gone", valid_o, 1'b0);

    // randomized traffic with wrap, full and bypass corners
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 5,
            $urandom_range(0, 31) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
